// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the PhilosophyV core: sequences fetch/decode/execute/memory/writeback
// with a ready/request memory handshake, a timeout watchdog and illegal-opcode trapping.
module multicycle_controller #(
  parameter int OPCODE_WIDTH    = 7,
  parameter int ALU_SRC_B_WIDTH = 2,
  parameter int WB_SRC_WIDTH    = 2,
  parameter int MEM_TIMEOUT     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OPCODE_WIDTH-1:0]    opCode,
  input  logic                       mem_ready,
  input  logic                       branchTaken,
  output logic                       PCWrite,
  output logic                       PCSrc,
  output logic                       IRWrite,
  output logic                       ALUOverride,
  output logic                       ALUSrcA,
  output logic [ALU_SRC_B_WIDTH-1:0] ALUSrcB,
  output logic                       regFileWrite,
  output logic [WB_SRC_WIDTH-1:0]    regFileWriteSrc,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic                       mem_addr_src,
  output logic                       illegal_instr,
  output logic                       mem_fault,
  output logic [3:0]                 state_out
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_ALU_R  = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_ALU_I  = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = OPCODE_WIDTH'(7'b1101111);

  localparam logic [ALU_SRC_B_WIDTH-1:0] SRCB_RS2  = ALU_SRC_B_WIDTH'(2'd0);
  localparam logic [ALU_SRC_B_WIDTH-1:0] SRCB_IMM  = ALU_SRC_B_WIDTH'(2'd1);
  localparam logic [ALU_SRC_B_WIDTH-1:0] SRCB_FOUR = ALU_SRC_B_WIDTH'(2'd2);
  localparam logic [WB_SRC_WIDTH-1:0]    WB_ALU_SRC = WB_SRC_WIDTH'(2'd0);
  localparam logic [WB_SRC_WIDTH-1:0]    WB_MEM_SRC = WB_SRC_WIDTH'(2'd1);
  localparam logic [WB_SRC_WIDTH-1:0]    WB_PC4_SRC = WB_SRC_WIDTH'(2'd2);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_TRAP   = 4'd11
  } state_t;

  state_t                       state_r, state_next_s;
  logic [CW-1:0]                tmo_cnt_r, tmo_cnt_next_s;
  logic                         mem_fault_r, is_store_r;
  logic                         in_mem_s, expire_s;
  logic                         pc_write_s, pc_src_s, ir_write_s, alu_override_s, alu_src_a_s;
  logic [ALU_SRC_B_WIDTH-1:0]   alu_src_b_s;
  logic                         rf_write_s, mem_req_s, mem_we_s, mem_addr_src_s, illegal_s;
  logic [WB_SRC_WIDTH-1:0]      rf_src_s;

  // Next-state, watchdog and Moore output decode
  always_comb begin
    state_next_s   = state_r;
    pc_write_s     = 1'b0;
    pc_src_s       = 1'b0;
    ir_write_s     = 1'b0;
    alu_override_s = 1'b0;
    alu_src_a_s    = 1'b0;
    alu_src_b_s    = SRCB_RS2;
    rf_write_s     = 1'b0;
    rf_src_s       = WB_ALU_SRC;
    mem_req_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_addr_src_s = 1'b0;
    illegal_s      = 1'b0;
    in_mem_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    // mem_ready in the expiring cycle wins over the timeout
    expire_s = in_mem_s && !mem_ready && (tmo_cnt_r == TMO_LAST);
    if (in_mem_s && !mem_ready && !expire_s) begin
      tmo_cnt_next_s = tmo_cnt_r + CW'(1);
    end else begin
      tmo_cnt_next_s = '0;
    end
    case (state_r)
      S_FETCH: begin
        mem_req_s      = 1'b1;
        alu_src_b_s    = SRCB_FOUR;
        alu_override_s = 1'b1;
        if (mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b_s    = SRCB_IMM;
        alu_override_s = 1'b1;
        case (opCode)
          OP_ALU_R:          state_next_s = S_EXEC_R;
          OP_ALU_I:          state_next_s = S_EXEC_I;
          OP_LOAD, OP_STORE: state_next_s = S_ADDR;
          OP_BRANCH:         state_next_s = S_BRANCH;
          OP_JAL:            state_next_s = S_JAL;
          default:           state_next_s = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_s  = 1'b1;
        state_next_s = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = SRCB_IMM;
        state_next_s = S_WB_ALU;
      end
      S_ADDR: begin
        alu_src_a_s    = 1'b1;
        alu_src_b_s    = SRCB_IMM;
        alu_override_s = 1'b1;
        state_next_s   = is_store_r ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_s      = 1'b1;
        mem_addr_src_s = 1'b1;
        if (mem_ready) begin
          state_next_s = S_WB_MEM;
        end else if (expire_s) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        mem_req_s      = 1'b1;
        mem_we_s       = 1'b1;
        mem_addr_src_s = 1'b1;
        if (mem_ready || expire_s) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEM_WR;
        end
      end
      S_WB_ALU: begin
        rf_write_s   = 1'b1;
        state_next_s = S_FETCH;
      end
      S_WB_MEM: begin
        rf_write_s   = 1'b1;
        rf_src_s     = WB_MEM_SRC;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s  = 1'b1;
        pc_write_s   = branchTaken;
        pc_src_s     = 1'b1;
        state_next_s = S_FETCH;
      end
      S_JAL: begin
        pc_write_s   = 1'b1;
        pc_src_s     = 1'b1;
        rf_write_s   = 1'b1;
        rf_src_s     = WB_PC4_SRC;
        state_next_s = S_FETCH;
      end
      S_TRAP: begin
        illegal_s    = 1'b1;
        state_next_s = S_FETCH;
      end
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

  // State, watchdog counter, sticky fault and load/store selector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_FETCH;
      tmo_cnt_r   <= '0;
      mem_fault_r <= 1'b0;
      is_store_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      tmo_cnt_r   <= tmo_cnt_next_s;
      mem_fault_r <= mem_fault_r | expire_s;
      if (state_r == S_DECODE) begin
        is_store_r <= (opCode == OP_STORE);
      end else begin
        is_store_r <= is_store_r;
      end
    end
  end

  // Write enables are suppressed while reset is held
  assign PCWrite         = pc_write_s & ~rst;
  assign IRWrite         = ir_write_s & ~rst;
  assign regFileWrite    = rf_write_s & ~rst;
  assign PCSrc           = pc_src_s;
  assign ALUOverride     = alu_override_s;
  assign ALUSrcA         = alu_src_a_s;
  assign ALUSrcB         = alu_src_b_s;
  assign regFileWriteSrc = rf_src_s;
  assign mem_req         = mem_req_s;
  assign mem_we          = mem_we_s;
  assign mem_addr_src    = mem_addr_src_s;
  assign illegal_instr   = illegal_s;
  assign mem_fault       = mem_fault_r;
  assign state_out       = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference model that expands
// each instruction into its expected per-cycle phase sequence, with randomized handshake delays.
module tb_multicycle_controller;
  localparam int TMO = 16;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3, P_ADDR = 4, P_MEM_RD = 5,
                 P_MEM_WR = 6, P_WB_ALU = 7, P_WB_MEM = 8, P_BRANCH = 9, P_JAL = 10, P_TRAP = 11;

  logic clk, rst, mem_ready, branchTaken;
  logic [6:0] opCode;
  logic PCWrite, PCSrc, IRWrite, ALUOverride, ALUSrcA, regFileWrite;
  logic [1:0] ALUSrcB, regFileWriteSrc;
  logic mem_req, mem_we, mem_addr_src, illegal_instr, mem_fault;
  logic [3:0] state_out;
  logic [18:0] obs;
  logic model_fault;
  int vectors = 0;
  int errs = 0;

  multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .mem_ready(mem_ready), .branchTaken(branchTaken),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .ALUOverride(ALUOverride),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .regFileWrite(regFileWrite),
    .regFileWriteSrc(regFileWriteSrc), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_src(mem_addr_src), .illegal_instr(illegal_instr), .mem_fault(mem_fault),
    .state_out(state_out)
  );

  assign obs = {PCWrite, PCSrc, IRWrite, ALUOverride, ALUSrcA, ALUSrcB, regFileWrite,
                regFileWriteSrc, mem_req, mem_we, mem_addr_src, illegal_instr, mem_fault, state_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for one cycle spent in phase ph
  function automatic logic [18:0] expect_vec(input int ph, input logic rdy, input logic bt,
                                             input logic flt);
    logic pcw, pcs, irw, ovr, srca, rfw, mrq, mwe, mas, ill;
    logic [1:0] srcb, wbs;
    {pcw, pcs, irw, ovr, srca, rfw, mrq, mwe, mas, ill} = 10'd0;
    srcb = 2'd0;
    wbs  = 2'd0;
    case (ph)
      P_FETCH:  begin mrq = 1'b1; srcb = 2'd2; ovr = 1'b1; irw = rdy; pcw = rdy; end
      P_DECODE: begin srcb = 2'd1; ovr = 1'b1; end
      P_EXEC_R: begin srca = 1'b1; end
      P_EXEC_I: begin srca = 1'b1; srcb = 2'd1; end
      P_ADDR:   begin srca = 1'b1; srcb = 2'd1; ovr = 1'b1; end
      P_MEM_RD: begin mrq = 1'b1; mas = 1'b1; end
      P_MEM_WR: begin mrq = 1'b1; mwe = 1'b1; mas = 1'b1; end
      P_WB_ALU: begin rfw = 1'b1; end
      P_WB_MEM: begin rfw = 1'b1; wbs = 2'd1; end
      P_BRANCH: begin srca = 1'b1; pcw = bt; pcs = 1'b1; end
      P_JAL:    begin pcw = 1'b1; pcs = 1'b1; rfw = 1'b1; wbs = 2'd2; end
      P_TRAP:   begin ill = 1'b1; end
      default:  begin end
    endcase
    return {pcw, pcs, irw, ovr, srca, srcb, rfw, wbs, mrq, mwe, mas, ill, flt, 4'(ph)};
  endfunction

  task automatic check(input string tag, input int ph, input logic rdy, input logic bt);
    logic [18:0] e;
    e = expect_vec(ph, rdy, bt, model_fault);
    vectors++;
    assert (obs === e) else begin
      errs++;
      $error("FAIL %s phase=%0d: got %h expected %h", tag, ph, obs, e);
    end
  endtask

  // One clock in phase ph: drive at negedge, check, advance to the next negedge
  task automatic step(input int ph, input logic rdy, input logic [6:0] op, input logic bt);
    mem_ready = rdy;
    opCode = op;
    branchTaken = bt;
    #1;
    check("step", ph, rdy, bt);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Non-memory phase: mem_ready, opCode and branchTaken are don't-cares, so randomize them
  task automatic nstep(input int ph);
    step(ph, 1'($urandom), 7'($urandom), 1'($urandom));
  endtask

  // Memory phase with d not-ready cycles; the watchdog fires on the TMO-th consecutive wait
  task automatic mem_wait(input int ph, input int d, output logic to);
    to = 1'b0;
    for (int k = 0; k <= d; k++) begin
      if (k == d) begin
        step(ph, 1'b1, 7'($urandom), 1'($urandom));
      end else begin
        step(ph, 1'b0, 7'($urandom), 1'($urandom));
        if (k == TMO - 1) begin
          model_fault = 1'b1;
          to = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int df, input int dm, input logic bt);
    logic to;
    mem_wait(P_FETCH, df, to);
    if (!to) begin
      step(P_DECODE, 1'($urandom), op, 1'($urandom));
      if (op == 7'b0110011) begin
        nstep(P_EXEC_R); nstep(P_WB_ALU);
      end else if (op == 7'b0010011) begin
        nstep(P_EXEC_I); nstep(P_WB_ALU);
      end else if (op == 7'b0000011) begin
        nstep(P_ADDR);
        mem_wait(P_MEM_RD, dm, to);
        if (!to) nstep(P_WB_MEM);
      end else if (op == 7'b0100011) begin
        nstep(P_ADDR);
        mem_wait(P_MEM_WR, dm, to);
      end else if (op == 7'b1100011) begin
        step(P_BRANCH, 1'($urandom), 7'($urandom), bt);
      end else if (op == 7'b1101111) begin
        nstep(P_JAL);
      end else begin
        nstep(P_TRAP);
      end
    end
  endtask

  initial begin
    logic [6:0] ops [6];
    logic to;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    model_fault = 1'b0;
    rst = 1'b1;
    mem_ready = 1'b1;
    opCode = 7'd0;
    branchTaken = 1'b0;
    @(negedge clk);
    #1;
    check("reset", P_FETCH, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed instructions
    run_instr(7'b0110011, 0, 0, 1'b0);
    run_instr(7'b0010011, 1, 0, 1'b0);
    run_instr(7'b0000011, 0, 3, 1'b0);
    run_instr(7'b0100011, 2, 2, 1'b0);
    run_instr(7'b1100011, 0, 0, 1'b1);
    run_instr(7'b1100011, 0, 0, 1'b0);
    run_instr(7'b1101111, 0, 0, 1'b0);
    run_instr(7'b1111111, 0, 0, 1'b0);
    run_instr(7'b0000011, TMO - 1, TMO - 1, 1'b0);
    run_instr(7'b0100011, 0, TMO - 1, 1'b0);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [6:0] op;
      sel = $urandom_range(0, 6);
      op = (sel == 6) ? 7'($urandom) : ops[sel];
      run_instr(op, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), 1'($urandom));
    end

    // Fetch timeout, then the same PC is re-fetched with the fault latched
    run_instr(7'b0110011, TMO, 0, 1'b0);
    run_instr(7'b0110011, 0, 0, 1'b0);
    run_instr(7'b0000011, 0, TMO, 1'b0);
    run_instr(7'b0100011, 0, TMO, 1'b0);
    run_instr(7'b1101111, 0, 0, 1'b0);

    // Reset in the middle of a load wait
    mem_wait(P_FETCH, 0, to);
    step(P_DECODE, 1'b0, 7'b0000011, 1'b0);
    nstep(P_ADDR);
    step(P_MEM_RD, 1'b0, 7'd0, 1'b0);
    step(P_MEM_RD, 1'b0, 7'd0, 1'b0);
    rst = 1'b1;
    mem_ready = 1'b1;
    model_fault = 1'b0;
    #1;
    check("mid_rd_reset", P_FETCH, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(P_FETCH, 1'b0, 7'd0, 1'b0);
    run_instr(7'b0110011, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Next-generation multicycle control FSM for the PhilosophyV core.
- Sequences fetch, decode, execute, memory and writeback for ALU-reg, ALU-imm, load, store, branch and JAL instructions.
- Adds a ready/request memory handshake with a timeout watchdog, plus illegal-opcode trapping.
- Sits between the instruction register opcode field and the datapath select and enable signals.

Parameters:
- OPCODE_WIDTH, 7, width of the opCode input.
- ALU_SRC_B_WIDTH, 2, width of the ALUSrcB select.
- WB_SRC_WIDTH, 2, width of the regFileWriteSrc select.
- MEM_TIMEOUT, 16, cycles to wait for mem_ready before flagging mem_fault (minimum 2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opCode  in  OPCODE_WIDTH  opcode field of the current instruction register.
- mem_ready  in  1  memory has completed the current request (read data valid / write accepted).
- branchTaken  in  1  branch comparison result from the ALU, valid during BRANCH.
- PCWrite  out  1  load the PC.
- PCSrc  out  1  0 = ALU result (PC+4 / target), 1 = latched ALU out.
- IRWrite  out  1  load the instruction register.
- ALUOverride  out  1  force the ALU to ADD.
- ALUSrcA  out  1  0 = PC, 1 = register rs1.
- ALUSrcB  out  ALU_SRC_B_WIDTH  0 = rs2, 1 = immediate, 2 = constant 4.
- regFileWrite  out  1  register file write enable.
- regFileWriteSrc  out  WB_SRC_WIDTH  0 = ALU/EX result, 1 = memory data, 2 = PC+4.
- mem_req  out  1  memory request active.
- mem_we  out  1  request is a write.
- mem_addr_src  out  1  0 = PC, 1 = ALU out.
- illegal_instr  out  1  one-cycle pulse when an unsupported opcode is decoded.
- mem_fault  out  1  sticky until reset; a memory request exceeded MEM_TIMEOUT.
- state_out  out  4  current state encoding, for debug.

Behaviour:
- Reset: asynchronous and active-high. Forces state=FETCH, timeout counter=0, mem_fault=0.
- Outputs are Moore-decoded from state and inputs. During reset all outputs take their FETCH values, except IRWrite, PCWrite and regFileWrite, which are 0.
- Defaults: every output is 0 unless listed for a state. There are no latches; every state drives every output.
- FETCH: mem_req=1, mem_addr_src=0, ALUSrcA=0, ALUSrcB=2, ALUOverride=1.
  - If mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, and the next state is DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=1, ALUOverride=1 (branch/JAL target precompute). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> TRAP
- EXEC_R: ALUSrcA=1, ALUSrcB=0. Next state WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=1. Next state WB_ALU.
- ADDR: ALUSrcA=1, ALUSrcB=1, ALUOverride=1. Next state MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, mem_addr_src=1. Moves to WB_MEM on mem_ready; otherwise holds.
- MEM_WR: mem_req=1, mem_we=1, mem_addr_src=1. Moves to FETCH on mem_ready; otherwise holds.
- WB_ALU: regFileWrite=1, regFileWriteSrc=0. Next state FETCH.
- WB_MEM: regFileWrite=1, regFileWriteSrc=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0. PCWrite=branchTaken, PCSrc=1. Next state FETCH.
- JAL: PCWrite=1, PCSrc=1, regFileWrite=1, regFileWriteSrc=2. Next state FETCH.
- TRAP: illegal_instr=1 for exactly one cycle. Next state FETCH. No register, PC or memory side effects.
- Timeout counter:
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Clears on mem_ready=1 or on leaving a memory state.
  - On reaching MEM_TIMEOUT-1 with mem_ready still 0: mem_fault is set, the counter clears, and the FSM moves to FETCH with no write-enable asserted.
  - A mem_fault raised in FETCH re-requests the same PC.
- mem_ready arriving in the same cycle the counter expires: mem_ready wins; no fault is raised.
- mem_ready outside memory states is ignored.
- opCode is sampled only in DECODE.

Test Plan:
- Reset asserted mid-MEM_RD -> state_out=FETCH immediately, regFileWrite=0, mem_fault=0; after release, FETCH with mem_req=1.
- ALU-reg 0110011, mem_ready tied 1 -> FETCH, DECODE, EXEC_R, WB_ALU (4 cycles); regFileWrite=1 only in WB_ALU; PCWrite=1 only in FETCH.
- Load 0000011 with mem_ready delayed 3 cycles in MEM_RD -> mem_req held for 4 cycles; WB_MEM has regFileWriteSrc=1; 8 cycles total.
- Branch 1100011 with branchTaken=1, then again with branchTaken=0 -> PCWrite=1 with PCSrc=1 in the first case; PCWrite=0 in BRANCH in the second.
- Opcode 1111111 -> TRAP, one-cycle illegal_instr pulse, then FETCH; no regFileWrite or mem_req in between.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> mem_fault rises after 16 cycles, FSM re-enters FETCH; mem_fault stays 1 until rst.
